battleship_fsm: RTL and testbench

BATTLESHIP_FSM -- requirements
Module: battleship_fsm

---
 rtl/bs_pkg.sv | 61 ++++++
 rtl/bs_word_display.sv | 39 +++
 rtl/battleship_fsm.sv | 115 +++++++++++
 tb/tb_battleship_fsm.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bs_pkg.sv
// Shared definitions for the battleship game controller.
// Holds the FSM state enum, the 3-bit word codes shown on the displays,
// and the active-low seven-segment glyphs used to spell those words.
// Segment bit order: {dp, g, f, e, d, c, b, a}; a 0 lights the segment, and dp is never lit.
package bs_pkg;

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_A_TURN,
      ST_A_FIRE,
      ST_B_TURN,
      ST_B_FIRE,
      ST_A_WIN,
      ST_B_WIN
   } bs_state_e;

   // Word codes driven on DispA / DispB. Codes 5-7 display as blank.
   localparam logic [2:0] LOAD = 3'd0;
   localparam logic [2:0] FIRE = 3'd1;
   localparam logic [2:0] WAIT = 3'd2;
   localparam logic [2:0] WIN  = 3'd3;
   localparam logic [2:0] LOSE = 3'd4;

   // Character glyphs. 'W' has no true seven-segment form, so it is drawn as a 'U' shape.
   localparam logic [7:0] CH_L     = 8'hC7;
   localparam logic [7:0] CH_O     = 8'hC0;
   localparam logic [7:0] CH_A     = 8'h88;
   localparam logic [7:0] CH_D     = 8'hA1;
   localparam logic [7:0] CH_F     = 8'h8E;
   localparam logic [7:0] CH_I     = 8'hF9;
   localparam logic [7:0] CH_R     = 8'hAF;
   localparam logic [7:0] CH_E     = 8'h86;
   localparam logic [7:0] CH_W     = 8'hC1;
   localparam logic [7:0] CH_T     = 8'h87;
   localparam logic [7:0] CH_DASH  = 8'hBF;
   localparam logic [7:0] CH_N     = 8'hAB;
   localparam logic [7:0] CH_S     = 8'h92;
   localparam logic [7:0] CH_BLANK = 8'hFF;

   // Glyph for character position idx of a word; position 0 is the leftmost character.
   function automatic logic [7:0] word_char(input logic [2:0] word, input logic [1:0] idx);
      logic [31:0] chars;
      logic [7:0]  glyph;
      case (word)
         LOAD:    chars = {CH_L,    CH_O, CH_A, CH_D};
         FIRE:    chars = {CH_F,    CH_I, CH_R, CH_E};
         WAIT:    chars = {CH_W,    CH_A, CH_I, CH_T};
         WIN:     chars = {CH_DASH, CH_W, CH_I, CH_N};
         LOSE:    chars = {CH_L,    CH_O, CH_S, CH_E};
         default: chars = {4{CH_BLANK}};
      endcase
      case (idx)
         2'd0:    glyph = chars[31:24];
         2'd1:    glyph = chars[23:16];
         2'd2:    glyph = chars[15:8];
         default: glyph = chars[7:0];
      endcase
      return glyph;
   endfunction

endpackage

// File: rtl/bs_word_display.sv
// Four-digit multiplexed seven-segment driver that spells one word code.
// Latency: seg/an are a combinational decode of the refresh counter and wordSelect, with no added delay.
// Backpressure: none; the refresh counter runs freely and is cleared only by clr.
// Ports: clk, clr (synchronous, active-high), wordSelect[2:0] (word code),
//        seg[7:0] (active-low, dp is bit 7), an[3:0] (active-low, an[3] = leftmost digit).
module bs_word_display
   import bs_pkg::*;
#(
   parameter int REFRESH_BITS = 17
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [2:0] wordSelect,
   output logic [7:0] seg,
   output logic [3:0] an
);

   logic [REFRESH_BITS-1:0] refresh_cnt;
   logic [1:0]              digit_sel;

   always_ff @(posedge clk) begin
      if (clr) refresh_cnt <= '0;
      else     refresh_cnt <= refresh_cnt + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
   end

   // The top two counter bits choose the digit, so each digit is held for 2^(REFRESH_BITS-2) cycles.
   assign digit_sel = refresh_cnt[REFRESH_BITS-1 -: 2];

   always_comb begin
      case (digit_sel)
         2'd0:    an = 4'b0111;
         2'd1:    an = 4'b1011;
         2'd2:    an = 4'b1101;
         default: an = 4'b1110;
      endcase
      seg = word_char(wordSelect, digit_sel);
   end

endmodule

// File: rtl/battleship_fsm.sv
// Turn-based battleship game controller: load, alternate fire turns, then declare a winner.
// Latency: all outputs are a Moore decode of the state register and change one cycle after the deciding inputs.
// Backpressure: none; an attack is taken only when a fire request and a valid selection arrive together.
// Ports: clk, clr (synchronous, active-high restart), BTN1 (ready), BTN2A/BTN2B (fire), OKA/OKB (selection valid),
//        LivA/LivB (ships alive), ST (started), LDR1A/LDR1B (ship load), LDR2A/LDR2B (attack load pulse),
//        DispA/DispB (word codes), seg/an (seven-segment display showing DispA).
// Build option: defining BS_SSEG_DISPLAY_EN adds the seven-segment driver; otherwise seg/an stay blank.
module battleship_fsm
   import bs_pkg::*;
#(
   parameter int REFRESH_BITS = 17
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       BTN1,
   input  logic       BTN2A,
   input  logic       BTN2B,
   input  logic       OKA,
   input  logic       OKB,
   input  logic       LivA,
   input  logic       LivB,
   output logic       ST,
   output logic       LDR1A,
   output logic       LDR1B,
   output logic       LDR2A,
   output logic       LDR2B,
   output logic [2:0] DispA,
   output logic [2:0] DispB,
   output logic [7:0] seg,
   output logic [3:0] an
);

   bs_state_e state, state_nxt;

   always_ff @(posedge clk) begin
      if (clr) state <= ST_LOAD;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ST        = 1'b1;
      LDR1A     = 1'b0;
      LDR1B     = 1'b0;
      LDR2A     = 1'b0;
      LDR2B     = 1'b0;
      DispA     = LOAD;
      DispB     = LOAD;

      case (state)
         ST_LOAD: begin
            ST    = 1'b0;
            LDR1A = 1'b1;
            LDR1B = 1'b1;
            if (BTN1) state_nxt = ST_A_TURN;
         end
         ST_A_TURN: begin
            DispA = FIRE;
            DispB = WAIT;
            // A sunk fleet ends the game before any pending fire request is honoured.
            if (!LivB)             state_nxt = ST_A_WIN;
            else if (!LivA)        state_nxt = ST_B_WIN;
            else if (BTN2A && OKA) state_nxt = ST_A_FIRE;
         end
         ST_A_FIRE: begin
            DispA     = FIRE;
            DispB     = WAIT;
            LDR2A     = 1'b1;
            state_nxt = ST_B_TURN;
         end
         ST_B_TURN: begin
            DispA = WAIT;
            DispB = FIRE;
            if (!LivB)             state_nxt = ST_A_WIN;
            else if (!LivA)        state_nxt = ST_B_WIN;
            else if (BTN2B && OKB) state_nxt = ST_B_FIRE;
         end
         ST_B_FIRE: begin
            DispA     = WAIT;
            DispB     = FIRE;
            LDR2B     = 1'b1;
            state_nxt = ST_A_TURN;
         end
         ST_A_WIN: begin
            DispA = WIN;
            DispB = LOSE;
         end
         ST_B_WIN: begin
            DispA = LOSE;
            DispB = WIN;
         end
         default: state_nxt = ST_LOAD;
      endcase
   end

   // The refresh counter needs at least the two digit-select bits.
   if (REFRESH_BITS < 2) begin : g_refresh_bits_too_small
   end

`ifdef BS_SSEG_DISPLAY_EN
   bs_word_display #(
      .REFRESH_BITS (REFRESH_BITS)
   ) u_word_display (
      .clk        (clk),
      .clr        (clr),
      .wordSelect (DispA),
      .seg        (seg),
      .an         (an)
   );
`else
   assign seg = 8'hFF;
   assign an  = 4'hF;
`endif

endmodule

// File: tb/tb_battleship_fsm.sv
// Self-checking bench for battleship_fsm: directed scenarios with literal expectations,
// then randomized play compared every cycle against a game-level reference model.
module tb_battleship_fsm;

   localparam int RB = 4;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       BTN1 = 1'b0, BTN2A = 1'b0, BTN2B = 1'b0, OKA = 1'b0, OKB = 1'b0;
   logic       LivA = 1'b1, LivB = 1'b1;
   logic       ST, LDR1A, LDR1B, LDR2A, LDR2B;
   logic [2:0] DispA, DispB;
   logic [7:0] seg;
   logic [3:0] an;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   always #5 clk = ~clk;

   battleship_fsm #(.REFRESH_BITS(RB)) dut (
      .clk   (clk),
      .clr   (clr),
      .BTN1  (BTN1),
      .BTN2A (BTN2A),
      .BTN2B (BTN2B),
      .OKA   (OKA),
      .OKB   (OKB),
      .LivA  (LivA),
      .LivB  (LivB),
      .ST    (ST),
      .LDR1A (LDR1A),
      .LDR1B (LDR1B),
      .LDR2A (LDR2A),
      .LDR2B (LDR2B),
      .DispA (DispA),
      .DispB (DispB),
      .seg   (seg),
      .an    (an)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: game facts, not states ----------------
   bit          m_started = 1'b0;  // ships loaded, game in progress or over
   bit          m_turn_b  = 1'b0;  // whose turn it is
   bit          m_firing  = 1'b0;  // the one-cycle attack load is in progress
   int          m_winner  = 0;     // 0 none, 1 player A, 2 player B
   logic [RB-1:0] m_cnt   = '0;    // refresh counter

   always @(posedge clk) begin
      m_cnt <= clr ? '0 : m_cnt + 1'b1;
      if (clr) begin
         m_started <= 1'b0;
         m_turn_b  <= 1'b0;
         m_firing  <= 1'b0;
         m_winner  <= 0;
      end else if (!m_started) begin
         if (BTN1) m_started <= 1'b1;
      end else if (m_winner != 0) begin
         m_winner <= m_winner;
      end else if (m_firing) begin
         m_firing <= 1'b0;
         m_turn_b <= !m_turn_b;
      end else if (!LivB) begin
         m_winner <= 1;
      end else if (!LivA) begin
         m_winner <= 2;
      end else if (m_turn_b ? (BTN2B && OKB) : (BTN2A && OKA)) begin
         m_firing <= 1'b1;
      end
   end

   // {ST, LDR1A, LDR1B, LDR2A, LDR2B, DispA, DispB}
   function automatic logic [10:0] exp_fsm();
      logic [2:0] da, db;
      logic       l2a, l2b;
      if (!m_started)        begin da = 3'd0; db = 3'd0; end
      else if (m_winner == 1) begin da = 3'd3; db = 3'd4; end
      else if (m_winner == 2) begin da = 3'd4; db = 3'd3; end
      else if (m_turn_b)      begin da = 3'd2; db = 3'd1; end
      else                    begin da = 3'd1; db = 3'd2; end
      l2a = m_started && (m_winner == 0) && m_firing && !m_turn_b;
      l2b = m_started && (m_winner == 0) && m_firing && m_turn_b;
      return {m_started, !m_started, !m_started, l2a, l2b, da, db};
   endfunction

`ifdef BS_SSEG_DISPLAY_EN
   // Expected glyphs per word code and digit (leftmost first), dp off.
   logic [7:0] glyph [0:7][0:3] = '{
      '{8'hC7, 8'hC0, 8'h88, 8'hA1},   // LOAd
      '{8'h8E, 8'hF9, 8'hAF, 8'h86},   // FIrE
      '{8'hC1, 8'h88, 8'hF9, 8'h87},   // WAIt
      '{8'hBF, 8'hC1, 8'hF9, 8'hAB},   // -WIn
      '{8'hC7, 8'hC0, 8'h92, 8'h86},   // LOSE
      '{8'hFF, 8'hFF, 8'hFF, 8'hFF},
      '{8'hFF, 8'hFF, 8'hFF, 8'hFF},
      '{8'hFF, 8'hFF, 8'hFF, 8'hFF}
   };
`endif

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         logic [10:0] e;
         e = exp_fsm();
         chk("fsm_outputs", 32'({ST, LDR1A, LDR1B, LDR2A, LDR2B, DispA, DispB}), 32'(e));
`ifdef BS_SSEG_DISPLAY_EN
         begin
            int sel;
            sel = int'(m_cnt[RB-1 -: 2]);
            chk("display", 32'({seg, an}), 32'({glyph[e[5:3]][sel], ~(4'b1000 >> sel)}));
         end
`else
         chk("display_off", 32'({seg, an}), 32'h0000_0FFF);
`endif
      end
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   // ---------------- stimulus with literal checks ----------------
   initial begin
      tick();
      tick();
      clr    = 1'b0;
      chk_en = 1'b1;
      chk("reset_outputs", 32'({ST, LDR1A, LDR1B, LDR2A, LDR2B, DispA, DispB}), 32'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0}));

`ifdef BS_SSEG_DISPLAY_EN
      begin
         logic [3:0] an_seq [0:3];
         logic [7:0] seg_seq[0:3];
         an_seq  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
         seg_seq = '{8'hC7, 8'hC0, 8'h88, 8'hA1};
         for (int i = 0; i < 16; i++) begin
            chk("load_an", 32'(an), 32'(an_seq[i/4]));
            chk("load_seg", 32'(seg), 32'(seg_seq[i/4]));
            tick();
         end
      end
`else
      chk("blank_display", 32'({seg, an}), 32'h0000_0FFF);
`endif

      // Start the game.
      BTN1 = 1'b1; tick(); BTN1 = 1'b0;
      chk("start", 32'({ST, LDR1A, LDR1B, DispA, DispB}), 32'({1'b1, 1'b0, 1'b0, 3'd1, 3'd2}));

      // A fires: one-cycle pulse, then B's turn.
      BTN2A = 1'b1; OKA = 1'b1; tick(); BTN2A = 1'b0; OKA = 1'b0;
      chk("a_fire_pulse", 32'({LDR2A, LDR2B, DispA}), 32'({1'b1, 1'b0, 3'd1}));
      tick();
      chk("b_turn", 32'({LDR2A, DispA, DispB}), 32'({1'b0, 3'd2, 3'd1}));

      // B fires back to return to A's turn.
      BTN2B = 1'b1; OKB = 1'b1; tick(); BTN2B = 1'b0; OKB = 1'b0;
      chk("b_fire_pulse", 32'({LDR2A, LDR2B}), 32'({1'b0, 1'b1}));
      tick();
      chk("a_turn_again", 32'({DispA, DispB}), 32'({3'd1, 3'd2}));

      // Fire without a valid selection (and B's button) is ignored.
      BTN2A = 1'b1; OKA = 1'b0; BTN2B = 1'b1; OKB = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("no_fire_hold", 32'({LDR2A, LDR2B, DispA}), 32'({1'b0, 1'b0, 3'd1}));
      end
      BTN2B = 1'b0; OKB = 1'b0;

      // Reset in the middle of A_FIRE.
      OKA = 1'b1; tick();
      chk("fire_before_clr", 32'(LDR2A), 32'd1);
      clr = 1'b1; BTN2A = 1'b0; OKA = 1'b0; tick(); clr = 1'b0;
      chk("clr_mid_fire", 32'({ST, LDR1A, LDR2A, DispA}), 32'({1'b0, 1'b1, 1'b0, 3'd0}));

      // B wins from B's turn; hold while buttons toggle.
      BTN1 = 1'b1; tick(); BTN1 = 1'b0;
      BTN2A = 1'b1; OKA = 1'b1; tick(); BTN2A = 1'b0; OKA = 1'b0;
      tick();
      LivA = 1'b0; tick(); LivA = 1'b1;
      chk("b_win", 32'({DispA, DispB}), 32'({3'd4, 3'd3}));
      for (int i = 0; i < 8; i++) begin
         {BTN1, BTN2A, BTN2B, OKA, OKB} = 5'($urandom);
         tick();
         chk("b_win_hold", 32'({ST, LDR2A, LDR2B, DispA, DispB}), 32'({1'b1, 1'b0, 1'b0, 3'd4, 3'd3}));
      end
      {BTN1, BTN2A, BTN2B, OKA, OKB} = 5'd0;

      // Both fleets gone in A's turn: A's win takes priority.
      clr = 1'b1; tick(); clr = 1'b0;
      BTN1 = 1'b1; tick(); BTN1 = 1'b0;
      LivA = 1'b0; LivB = 1'b0; tick(); LivA = 1'b1; LivB = 1'b1;
      chk("a_win_priority", 32'({DispA, DispB}), 32'({3'd3, 3'd4}));

      // Randomized play, checked every cycle by the compare process.
      for (int i = 0; i < 3000; i++) begin
         clr   = ($urandom_range(0, 63) == 0);
         BTN1  = ($urandom_range(0, 3) == 0);
         BTN2A = $urandom_range(0, 1) == 1;
         BTN2B = $urandom_range(0, 1) == 1;
         OKA   = $urandom_range(0, 1) == 1;
         OKB   = $urandom_range(0, 1) == 1;
         LivA  = ($urandom_range(0, 15) != 0);
         LivB  = ($urandom_range(0, 15) != 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
